// File: rtl/mprj_mem_arbiter.sv
// Shares the single-port user SRAM between the Wishbone slave and the core load/store port.
// Optional control register (core reset + user IRQ) built when MPRJ_MEM_ARB_CTRL_EN is defined.
module mprj_mem_arbiter #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [3:0]        core_be_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [31:0]       core_wdata_i,
    output logic              core_gnt_o,
    output logic              core_rvalid_o,
    output logic [31:0]       core_rdata_o,
    output logic              core_rst_o,
    output logic              irq_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_e;

    state_e      state_q, state_d;
    logic        last_wb_q, last_wb_d;
    logic        acc_ctrl_q, acc_ctrl_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        wb_hit, sram_hit, ctrl_hit, core_req, wb_win;
    logic [31:0] ctrl_rd;
    logic        unused_bits;

`ifdef MPRJ_MEM_ARB_CTRL_EN
    logic [1:0] ctrl_q, ctrl_d;
    assign ctrl_rd    = {30'b0, ctrl_q};
    assign core_rst_o = ctrl_q[0];
    assign irq_o      = ctrl_q[1];
`else
    assign ctrl_rd    = 32'b0;
    assign core_rst_o = 1'b0;
    assign irq_o      = 1'b0;
`endif

    assign wb_hit   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_ADDR[31:24]);
    assign sram_hit = wb_hit & ~wbs_adr_i[23];
    assign ctrl_hit = wb_hit & wbs_adr_i[23];
    assign core_req = core_req_i & ~core_rst_o;

    assign core_rvalid_o = rvalid_q;
    assign core_rdata_o  = mem_rdata_i;
    assign unused_bits   = ^{wbs_adr_i[22:ADDR_W+2], wbs_adr_i[1:0]};

    // last_wb_q starts clear so the core takes the first contested slot; it flips on
    // every contested slot so the two requesters alternate.
    always_comb begin
        state_d     = state_q;
        last_wb_d   = last_wb_q;
        acc_ctrl_d  = acc_ctrl_q;
        rdata_d     = rdata_q;
        wb_win      = 1'b0;
        core_gnt_o  = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 4'b0;
        mem_addr_o  = '0;
        mem_wdata_o = 32'b0;
        wbs_ack_o   = 1'b0;
        wbs_dat_o   = rdata_q;
`ifdef MPRJ_MEM_ARB_CTRL_EN
        ctrl_d      = ctrl_q;
`endif
        if (!wb_rst_i) begin
            case (state_q)
                IDLE: begin
                    wb_win = sram_hit & (~core_req | last_wb_q);
                    if (sram_hit && core_req) begin
                        last_wb_d = ~last_wb_q;
                    end
                    if (wb_win) begin
                        state_d    = ISSUE;
                        acc_ctrl_d = 1'b0;
                    end else begin
                        if (core_req) begin
                            core_gnt_o  = 1'b1;
                            mem_en_o    = 1'b1;
                            mem_we_o    = core_we_i ? core_be_i : 4'b0;
                            mem_addr_o  = core_addr_i;
                            mem_wdata_o = core_wdata_i;
                        end
                        if (ctrl_hit) begin
                            state_d    = DATA;
                            acc_ctrl_d = 1'b1;
`ifdef MPRJ_MEM_ARB_CTRL_EN
                            if (wbs_we_i && wbs_sel_i[0]) begin
                                ctrl_d = wbs_dat_i[1:0];
                            end
`endif
                        end
                    end
                end
                ISSUE: begin
                    mem_en_o    = 1'b1;
                    mem_we_o    = wbs_we_i ? wbs_sel_i : 4'b0;
                    mem_addr_o  = wbs_adr_i[ADDR_W+1:2];
                    mem_wdata_o = wbs_dat_i;
                    state_d     = DATA;
                end
                DATA: begin
                    wbs_ack_o = 1'b1;
                    if (wbs_we_i) begin
                        wbs_dat_o = 32'b0;
                    end else begin
                        wbs_dat_o = acc_ctrl_q ? ctrl_rd : mem_rdata_i;
                    end
                    rdata_d = wbs_dat_o;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rvalid_d = core_gnt_o & ~core_we_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            last_wb_q  <= 1'b0;
            acc_ctrl_q <= 1'b0;
            rdata_q    <= 32'b0;
            rvalid_q   <= 1'b0;
`ifdef MPRJ_MEM_ARB_CTRL_EN
            ctrl_q     <= 2'b01;
`endif
        end else begin
            state_q    <= state_d;
            last_wb_q  <= last_wb_d;
            acc_ctrl_q <= acc_ctrl_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
`ifdef MPRJ_MEM_ARB_CTRL_EN
            ctrl_q     <= ctrl_d;
`endif
        end
    end

endmodule

// File: tb/tb_mprj_mem_arbiter.sv
// Directed scoreboard bench for mprj_mem_arbiter; expected values adapt to MPRJ_MEM_ARB_CTRL_EN.
module tb_mprj_mem_arbiter;

    localparam int ADDR_W = 10;
`ifdef MPRJ_MEM_ARB_CTRL_EN
    localparam bit CtrlEn = 1'b1;
`else
    localparam bit CtrlEn = 1'b0;
`endif

    logic              wb_clk_i, wb_rst_i;
    logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i, wbs_dat_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;
    logic              core_req_i, core_we_i;
    logic [3:0]        core_be_i;
    logic [ADDR_W-1:0] core_addr_i;
    logic [31:0]       core_wdata_i;
    logic              core_gnt_o, core_rvalid_o;
    logic [31:0]       core_rdata_o;
    logic              core_rst_o, irq_o;
    logic              mem_en_o;
    logic [3:0]        mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] wbQ[$];
    logic [31:0] coreQ[$];
    logic [31:0] sram[0:(1<<ADDR_W)-1];

    mprj_mem_arbiter #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h3000_0000)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_be_i(core_be_i),
        .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
        .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
        .core_rst_o(core_rst_o), .irq_o(irq_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // Behavioural SRAM macro: byte-masked write, registered read one cycle after enable.
    always @(posedge wb_clk_i) begin
        if (mem_en_o) begin
            mem_rdata_i <= sram[mem_addr_o];
            for (int b = 0; b < 4; b++) begin
                if (mem_we_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One Wishbone classic transfer; called at posedge+1, returns at posedge+1 after the ack.
    task automatic applyStimulus(input string tag, input logic we, input logic [31:0] adr,
                                 input logic [3:0] sel, input logic [31:0] dat,
                                 input int expLat, input logic [31:0] expData);
        bit done = 1'b0;
        int lat  = -1;
        if (!we) wbQ.push_back(expData);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_sel_i = sel;  wbs_dat_i = dat;
        for (int c = 1; c <= 8 && !done; c++) begin
            @(negedge wb_clk_i);
            if (!adr[23] && expLat == 2 && c == 2) begin
                checkOutput({tag, " mem_en"}, 32'(mem_en_o), 32'd1);
                checkOutput({tag, " mem_addr"}, 32'(mem_addr_o), 32'(adr[ADDR_W+1:2]));
                checkOutput({tag, " mem_we"}, 32'(mem_we_o), we ? 32'(sel) : 32'd0);
            end
            if (wbs_ack_o === 1'b1) begin
                done = 1'b1;
                lat  = c - 1;
                if (!we) checkOutput({tag, " rdata"}, wbs_dat_o, wbQ.pop_front());
            end
        end
        checkOutput({tag, " ack latency"}, 32'(lat), 32'(expLat));
        if (!done) wbQ.delete();
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    logic [11:0] gntTbl = 12'b1111_0001_0001;
    logic [11:0] ackTbl = 12'b0000_1000_1000;
    logic        prevGnt;
    logic        ackSeen;

    initial begin
        wb_rst_i = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'b0; wbs_adr_i = 32'b0; wbs_dat_i = 32'b0;
        core_req_i = 1'b0; core_we_i = 1'b0; core_be_i = 4'b0;
        core_addr_i = '0; core_wdata_i = 32'b0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        core_req_i = 1'b1;
        @(negedge wb_clk_i);
        checkOutput("reset ack", 32'(wbs_ack_o), 32'd0);
        checkOutput("reset dat", wbs_dat_o, 32'd0);
        checkOutput("reset rvalid", 32'(core_rvalid_o), 32'd0);
        checkOutput("reset irq", 32'(irq_o), 32'd0);
        checkOutput("reset mem_we", 32'(mem_we_o), 32'd0);
        checkOutput("reset core_rst", 32'(core_rst_o), CtrlEn ? 32'd1 : 32'd0);
        checkOutput("reset core_gnt", 32'(core_gnt_o), CtrlEn ? 32'd0 : 32'd1);
        @(posedge wb_clk_i); #1;
        core_req_i = 1'b0;

        applyStimulus("ctrl read", 1'b0, 32'h3080_0000, 4'hF, 32'h0, 1, CtrlEn ? 32'h1 : 32'h0);
        applyStimulus("wr word4", 1'b1, 32'h3000_0010, 4'hF, 32'hDEADBEEF, 2, 32'h0);
        applyStimulus("rd word4", 1'b0, 32'h3000_0010, 4'hF, 32'h0, 2, 32'hDEADBEEF);
        applyStimulus("byte wr", 1'b1, 32'h3000_0010, 4'b0010, 32'h0000AA00, 2, 32'h0);
        applyStimulus("rd merged", 1'b0, 32'h3000_0010, 4'hF, 32'h0, 2, 32'hDEADAAEF);
        applyStimulus("wr word5", 1'b1, 32'h3000_0014, 4'hF, 32'h12345678, 2, 32'h0);
        applyStimulus("release", 1'b1, 32'h3080_0000, 4'hF, 32'h0, 1, 32'h0);
        @(negedge wb_clk_i);
        checkOutput("release core_rst", 32'(core_rst_o), 32'd0);
        @(posedge wb_clk_i); #1;

        // Core streams reads of word 4 while Wishbone back-to-back reads word 5.
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 10'd4;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 32'h3000_0014; wbs_sel_i = 4'hF;
        wbQ.push_back(32'h12345678);
        wbQ.push_back(32'h12345678);
        prevGnt = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 8) begin
                wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            end
            @(negedge wb_clk_i);
            checkOutput($sformatf("alt gnt c%0d", i), 32'(core_gnt_o), 32'(gntTbl[i]));
            checkOutput($sformatf("alt ack c%0d", i), 32'(wbs_ack_o), 32'(ackTbl[i]));
            checkOutput($sformatf("alt rvalid c%0d", i), 32'(core_rvalid_o), 32'(prevGnt));
            if (wbs_ack_o === 1'b1 && wbQ.size() > 0)
                checkOutput($sformatf("alt wb data c%0d", i), wbs_dat_o, wbQ.pop_front());
            if (core_rvalid_o === 1'b1 && coreQ.size() > 0)
                checkOutput($sformatf("alt core data c%0d", i), core_rdata_o, coreQ.pop_front());
            if (i == 2 || i == 6)
                checkOutput($sformatf("alt mem_addr c%0d", i), 32'(mem_addr_o), 32'd5);
            if (gntTbl[i]) coreQ.push_back(32'hDEADAAEF);
            prevGnt = gntTbl[i];
            @(posedge wb_clk_i); #1;
        end
        core_req_i = 1'b0;
        @(negedge wb_clk_i);
        checkOutput("tail rvalid", 32'(core_rvalid_o), 32'd1);
        if (coreQ.size() > 0) checkOutput("tail core data", core_rdata_o, coreQ.pop_front());
        coreQ.delete();
        wbQ.delete();
        @(posedge wb_clk_i); #1;

        applyStimulus("irq set", 1'b1, 32'h3080_0000, 4'hF, 32'h2, 1, 32'h0);
        @(negedge wb_clk_i);
        checkOutput("irq set irq", 32'(irq_o), CtrlEn ? 32'd1 : 32'd0);
        checkOutput("irq set core_rst", 32'(core_rst_o), 32'd0);
        @(posedge wb_clk_i); #1;
        applyStimulus("irq clr", 1'b1, 32'h3080_0000, 4'hF, 32'h0, 1, 32'h0);
        @(negedge wb_clk_i);
        checkOutput("irq clr irq", 32'(irq_o), 32'd0);
        checkOutput("irq clr core_rst", 32'(core_rst_o), 32'd0);
        @(posedge wb_clk_i); #1;

        // Reset arriving together with a core read leaves no rvalid behind.
        core_req_i = 1'b1; core_addr_i = 10'd4; wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        core_req_i = 1'b0; wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        checkOutput("reset drops rvalid", 32'(core_rvalid_o), 32'd0);
        checkOutput("re-reset core_rst", 32'(core_rst_o), CtrlEn ? 32'd1 : 32'd0);
        @(posedge wb_clk_i); #1;

        // Reset during the ISSUE cycle of a Wishbone SRAM read.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 32'h3000_0010; wbs_sel_i = 4'hF;
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge wb_clk_i);
        ackSeen = wbs_ack_o;
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        repeat (3) begin
            @(negedge wb_clk_i);
            ackSeen = ackSeen | wbs_ack_o;
        end
        checkOutput("issue reset no ack", 32'(ackSeen), 32'd0);
        checkOutput("issue reset core_rst", 32'(core_rst_o), CtrlEn ? 32'd1 : 32'd0);
        @(posedge wb_clk_i); #1;
        applyStimulus("post reset rd", 1'b0, 32'h3000_0010, 4'hF, 32'h0, 2, 32'hDEADAAEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mprj_mem_arbiter.md
# mprj_mem_arbiter

Shares the single-port 32-bit user SRAM between the management-SoC Wishbone slave port and the RISC-V core's load/store port inside the user project. Wishbone accesses load programs and inspect memory; a control register holds the core in reset during loading and raises a user IRQ on request. It sits directly behind the wrapper's `wbs_*` pins and in front of the SRAM macro.

## Interface
- `ADDR_W`, 10: SRAM word-address width (1024 words).
- `BASE_ADDR`, 32'h3000_0000: Wishbone window base; bits [31:24] decoded.
- `wb_clk_i` in 1: single clock for the whole block.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: Wishbone classic control.
- `wbs_sel_i` in 4: byte enables. `wbs_adr_i` in 32: byte address. `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: one-cycle ack. `wbs_dat_o` out 32: read data, valid with ack.
- `core_req_i`, `core_we_i` in 1 each; `core_be_i` in 4; `core_addr_i` in ADDR_W (word); `core_wdata_i` in 32.
- `core_gnt_o` out 1: request accepted this cycle (combinational).
- `core_rvalid_o` out 1: read data valid, one cycle after a granted read; `core_rdata_o` out 32.
- `core_rst_o` out 1: core reset, from control register.
- `irq_o` out 1: to `user_irq[0]`.
- `mem_en_o` out 1; `mem_we_o` out 4; `mem_addr_o` out ADDR_W; `mem_wdata_o` out 32; `mem_rdata_i` in 32 (data valid cycle after `mem_en_o`).

## Operation
- Decode: hit = `wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24]==BASE_ADDR[31:24])`. `wbs_adr_i[23]`=0 → SRAM, word index `wbs_adr_i[ADDR_W+1:2]`; =1 → control register (all low bits ignored). Non-hit strobes are ignored (no ack).
- Wishbone FSM: IDLE → (SRAM hit, granted) ISSUE → DATA → IDLE; IDLE → (control hit) DATA → IDLE. ack asserted in DATA for exactly one cycle. Ungranted SRAM hit stays in IDLE.
- Arbitration, evaluated in IDLE each cycle, only one SRAM access per cycle:
  - only one requester → it wins; both → the one not granted last (`last_wb` flag, reset 0 = core wins first tie).
  - WB win: SRAM port driven in ISSUE cycle; core not granted during ISSUE or DATA of a WB SRAM access (two-cycle lockout).
  - core win: `core_gnt_o`=1, `mem_*` driven combinationally from core inputs same cycle.
- `mem_we_o` = sel/be when write, else 0. WB read data latched from `mem_rdata_i` in DATA. `core_rvalid_o` = registered (grant & ~we); `core_rdata_o` = `mem_rdata_i` passthrough.
- Writes with zero byte enables still consume a slot and ack.
- Control register (32b): bit0 `core_rst` (reset 1), bit1 `irq` (reset 0); others read 0. Write updates per `wbs_sel_i[0]`. `irq_o` = bit1; write 0 clears.
- `core_req_i` ignored while `core_rst_o`=1 (no grant).

## Timing
- Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, `core_gnt_o`=0, `core_rvalid_o`=0, `core_rst_o`=1, `irq_o`=0, `mem_en_o`=0, `mem_we_o`=0, FSM=IDLE, `last_wb`=0.
- WB SRAM access: strobe in IDLE at cycle N (granted) → ack at N+2. Control access: ack at N+1.
- Core read granted at N → rvalid at N+1; back-to-back core reads sustain one per cycle when WB idle.
- Reset asserted mid-transaction: FSM returns to IDLE next edge, no ack issued, pending rvalid dropped.
- Master drops stb after ack; FSM in IDLE re-evaluates same-cycle stb (classic, no retries).

## Configuration
- `MPRJ_MEM_ARB_CTRL_EN` defined: control register as above.
- Undefined: no register; `core_rst_o`=0 and `irq_o`=0 constantly; control-space hits ack at N+1 with `wbs_dat_o`=0, writes dropped.

## Test plan
- Reset: after `wb_rst_i` pulse, read 0x3080_0000 → ack at N+1, data 0x1; `core_gnt_o` stays 0 with `core_req_i`=1.
- WB write 0x3000_0010 = 0xDEADBEEF sel=4'b1111, then read → ack at N+2, data 0xDEADBEEF; `mem_addr_o`=4.
- Byte write sel=4'b0010 data 0x0000AA00 over 0xDEADBEEF → readback 0xDEADAAEF.
- Release core (write 0x0 to control), core reads word 4 continuously while WB reads word 5 → grants alternate, WB ack at N+2 after win, core rvalid data 0xDEADAAEF.
- Write 0x2 to control → `irq_o`=1; write 0x0 → `irq_o`=0, `core_rst_o`=0.
- Assert reset during WB ISSUE → no ack, `core_rst_o`=1, next WB read completes normally.
